// File: rtl/led_pattern_rotator_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_rotator_if
// Brief    : Valid/ready load channel carrying a new base pattern into the
//            LED pattern rotator.
// Revision : 1.0 - initial release
// ============================================================================
interface led_pattern_rotator_if #(
  parameter int LED_WIDTH = 12
);

  logic                 load_valid;
  logic [LED_WIDTH-1:0] load_pattern;
  logic                 load_ready;

  // Pattern source side
  modport master (
    output load_valid,
    output load_pattern,
    input  load_ready
  );

  // Rotator side
  modport slave (
    input  load_valid,
    input  load_pattern,
    output load_ready
  );

endinterface
`default_nettype wire

// File: rtl/led_pattern_rotator.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_rotator
// Brief    : Steps an N-bit LED pattern at a prescaled rate with rotate-left,
//            rotate-right, bounce and hold modes. A valid/ready channel loads
//            a new pattern at run time; step and wrap strobes are exported.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_rotator #(
  parameter int                   LED_WIDTH    = 12,
  parameter logic [LED_WIDTH-1:0] BASE_PATTERN = 12'b000011101101,
  parameter int                   TICK_DIV     = 33554432
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 en,
  input  wire logic [1:0]           mode,
  led_pattern_rotator_if.slave      load,
  output logic      [LED_WIDTH-1:0] led,
  output logic                      step_pulse,
  output logic                      wrap_pulse
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int PCNT_W = $clog2(TICK_DIV);
  localparam int POS_W  = $clog2(LED_WIDTH);

  localparam logic [PCNT_W-1:0] c_PCNT_LAST = PCNT_W'(TICK_DIV - 1);
  localparam logic [PCNT_W-1:0] c_PCNT_ONE  = PCNT_W'(1);
  localparam logic [POS_W-1:0]  c_POS_LAST  = POS_W'(LED_WIDTH - 1);
  localparam logic [POS_W-1:0]  c_POS_ONE   = POS_W'(1);

  localparam logic [1:0] c_MODE_LEFT   = 2'b00;
  localparam logic [1:0] c_MODE_RIGHT  = 2'b01;
  localparam logic [1:0] c_MODE_BOUNCE = 2'b10;

  // Two-state control FSM: RUN steps the pattern, LOAD commits a new one
  localparam logic [0:0] c_ST_RUN  = 1'b0;
  localparam logic [0:0] c_ST_LOAD = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]           r_state;
  logic                 r_load_ready;
  logic [LED_WIDTH-1:0] r_hold;
  logic [PCNT_W-1:0]    r_pcnt;
  logic [POS_W-1:0]     r_pos;
  logic                 r_dir;
  logic [LED_WIDTH-1:0] r_led;
  logic                 r_step_pulse;
  logic                 r_wrap_pulse;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic                 w_in_run;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_step;
  logic [LED_WIDTH-1:0] w_rotl;
  logic [LED_WIDTH-1:0] w_rotr;
  logic [POS_W-1:0]     w_pos_inc;
  logic [POS_W-1:0]     w_pos_dec;
  logic [LED_WIDTH-1:0] w_next_led;
  logic [POS_W-1:0]     w_next_pos;
  logic                 w_next_dir;
  logic                 w_wrap;

  assign w_in_run = (r_state == c_ST_RUN);
  assign w_tick   = w_in_run && en && (r_pcnt == c_PCNT_LAST);
  assign w_accept = w_in_run && load.load_valid && r_load_ready;
  // An accepted load swallows a coincident tick: the pattern is about to be
  // replaced, so stepping it would only produce a misleading strobe.
  assign w_step   = w_tick && !w_accept;

  assign w_rotl = {r_led[LED_WIDTH-2:0], r_led[LED_WIDTH-1]};
  assign w_rotr = {r_led[0], r_led[LED_WIDTH-1:1]};

  // Explicit modular wrap so non-power-of-two widths stay in range
  assign w_pos_inc = (r_pos == c_POS_LAST) ? '0 : (r_pos + c_POS_ONE);
  assign w_pos_dec = (r_pos == '0) ? c_POS_LAST : (r_pos - c_POS_ONE);

  // Select the next pattern, position and bounce direction for a step
  always_comb begin
    w_next_led = r_led;
    w_next_pos = r_pos;
    w_next_dir = r_dir;
    case (mode)
      c_MODE_LEFT: begin
        w_next_led = w_rotl;
        w_next_pos = w_pos_inc;
      end
      c_MODE_RIGHT: begin
        w_next_led = w_rotr;
        w_next_pos = w_pos_dec;
      end
      c_MODE_BOUNCE: begin
        if (!r_dir) begin
          w_next_led = w_rotl;
          w_next_pos = w_pos_inc;
          if (w_pos_inc == c_POS_LAST) begin
            w_next_dir = 1'b1;
          end
        end else begin
          w_next_led = w_rotr;
          w_next_pos = w_pos_dec;
          if (w_pos_dec == '0) begin
            w_next_dir = 1'b0;
          end
        end
      end
      default: begin
        // Hold: pattern, position and direction stay put
        w_next_led = r_led;
        w_next_pos = r_pos;
        w_next_dir = r_dir;
      end
    endcase
  end

  // A wrap is only a transition into position 0, never sitting at 0
  assign w_wrap = (r_pos != '0) && (w_next_pos == '0);

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Control FSM and registered ready; ready stays low for the first cycle
  // after reset and for the whole LOAD cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_RUN;
      r_load_ready <= 1'b0;
    end else begin
      case (r_state)
        c_ST_RUN: begin
          if (w_accept) begin
            r_state      <= c_ST_LOAD;
            r_load_ready <= 1'b0;
          end else begin
            r_load_ready <= 1'b1;
          end
        end
        c_ST_LOAD: begin
          r_state      <= c_ST_RUN;
          r_load_ready <= 1'b1;
        end
        default: begin
          r_state      <= c_ST_RUN;
          r_load_ready <= 1'b0;
        end
      endcase
    end
  end

  // Capture the offered pattern on the accept edge so the source is free
  // to change it immediately after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= BASE_PATTERN;
    end else if (w_accept) begin
      r_hold <= load.load_pattern;
    end
  end

  // Prescaler: counts enabled cycles, wraps on a tick, clears on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (r_state == c_ST_LOAD) begin
      r_pcnt <= '0;
    end else if (!w_accept) begin
      if (w_tick) begin
        r_pcnt <= '0;
      end else if (en) begin
        r_pcnt <= r_pcnt + c_PCNT_ONE;
      end
    end
  end

  // Pattern datapath: commit a loaded pattern or apply one step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= BASE_PATTERN;
      r_pos <= '0;
      r_dir <= 1'b0;
    end else if (r_state == c_ST_LOAD) begin
      r_led <= r_hold;
      r_pos <= '0;
      r_dir <= 1'b0;
    end else if (w_step) begin
      r_led <= w_next_led;
      r_pos <= w_next_pos;
      r_dir <= w_next_dir;
    end
  end

  // Strobes coincide with the first cycle the stepped pattern is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_pulse <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      r_wrap_pulse <= w_step && w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign led             = r_led;
  assign step_pulse      = r_step_pulse;
  assign wrap_pulse      = r_wrap_pulse;
  assign load.load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_rotator.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_rotator
// Brief    : Directed self-checking bench for led_pattern_rotator
//            (LED_WIDTH = 12, BASE_PATTERN = 0x0ED, TICK_DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_rotator;

  localparam int         LED_WIDTH = 12;
  localparam int         TICK_DIV  = 4;
  localparam logic [11:0] BASE     = 12'h0ED;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] led;
  logic        step_pulse;
  logic        wrap_pulse;

  int vectors    = 0;
  int miscompares = 0;

  led_pattern_rotator_if #(.LED_WIDTH(LED_WIDTH)) load_if ();

  led_pattern_rotator #(
    .LED_WIDTH   (LED_WIDTH),
    .BASE_PATTERN(BASE),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .load       (load_if),
    .led        (led),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rotl(input logic [11:0] v);
    return {v[10:0], v[11]};
  endfunction

  function automatic logic [11:0] rotr(input logic [11:0] v);
    return {v[0], v[11:1]};
  endfunction

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] exp_led;

    rst                  = 1'b1;
    en                   = 1'b0;
    mode                 = 2'b00;
    load_if.load_valid   = 1'b0;
    load_if.load_pattern = 12'h000;

    // ---------------- 1: reset and rotate left ----------------
    step_clk();
    step_clk();
    check("rst_led",        led,                BASE);
    check("rst_ready",      load_if.load_ready, 1'b0);
    check("rst_step",       step_pulse,         1'b0);
    check("rst_wrap",       wrap_pulse,         1'b0);
    rst  = 1'b0;
    en   = 1'b1;
    mode = 2'b00;
    step_clk();
    check("rel_ready",      load_if.load_ready, 1'b1);
    check("rel_led",        led,                12'h0ED);
    step_clk();
    step_clk();
    check("pre_step_pulse", step_pulse,         1'b0);
    step_clk();
    check("l_step1_led",    led,                12'h1DA);
    check("l_step1_pulse",  step_pulse,         1'b1);
    check("l_step1_wrap",   wrap_pulse,         1'b0);
    step_clk();
    check("l_after_pulse",  step_pulse,         1'b0);
    repeat (3) step_clk();
    check("l_step2_led",    led,                12'h3B4);
    exp_led = 12'h3B4;
    for (int s = 3; s <= 12; s++) begin
      repeat (TICK_DIV) step_clk();
      exp_led = rotl(exp_led);
      check($sformatf("l_step%0d_led", s),   led,        exp_led);
      check($sformatf("l_step%0d_pulse", s), step_pulse, 1'b1);
      check($sformatf("l_step%0d_wrap", s),  wrap_pulse, (s == 12) ? 1'b1 : 1'b0);
    end
    check("l_full_cycle",   led,                12'h0ED);

    // ---------------- 2: rotate right from reset ----------------
    rst  = 1'b1;
    mode = 2'b01;
    step_clk();
    step_clk();
    check("r_rst_led",      led,                BASE);
    rst = 1'b0;
    repeat (TICK_DIV) step_clk();
    check("r_step1_led",    led,                12'h876);
    check("r_step1_wrap",   wrap_pulse,         1'b0);
    exp_led = 12'h876;
    for (int s = 2; s <= 12; s++) begin
      repeat (TICK_DIV) step_clk();
      exp_led = rotr(exp_led);
      check($sformatf("r_step%0d_led", s),  led,        exp_led);
      check($sformatf("r_step%0d_wrap", s), wrap_pulse, (s == 12) ? 1'b1 : 1'b0);
    end
    check("r_full_cycle",   led,                12'h0ED);

    // ---------------- 3: load 0x001 and bounce ----------------
    mode                 = 2'b10;
    load_if.load_valid   = 1'b1;
    load_if.load_pattern = 12'h001;
    step_clk();
    check("b_accept_ready", load_if.load_ready, 1'b0);
    check("b_accept_led",   led,                12'h0ED);
    load_if.load_valid   = 1'b0;
    load_if.load_pattern = 12'hFFF;
    step_clk();
    check("b_commit_led",   led,                12'h001);
    check("b_commit_ready", load_if.load_ready, 1'b1);
    for (int s = 1; s <= 23; s++) begin
      repeat (TICK_DIV) step_clk();
      if (s <= 11)      exp_led = 12'(1 << s);
      else if (s <= 22) exp_led = 12'(1 << (22 - s));
      else              exp_led = 12'h002;
      check($sformatf("b_step%0d_led", s),  led,        exp_led);
      check($sformatf("b_step%0d_wrap", s), wrap_pulse, (s == 22) ? 1'b1 : 1'b0);
    end

    // ---------------- 4: load colliding with a tick ----------------
    mode = 2'b00;
    repeat (TICK_DIV - 1) step_clk();
    load_if.load_valid   = 1'b1;
    load_if.load_pattern = 12'hAAA;
    step_clk();
    check("c_accept_step",  step_pulse,         1'b0);
    check("c_accept_ready", load_if.load_ready, 1'b0);
    check("c_accept_led",   led,                12'h002);
    load_if.load_valid   = 1'b0;
    load_if.load_pattern = 12'h000;
    step_clk();
    check("c_commit_led",   led,                12'hAAA);
    check("c_commit_ready", load_if.load_ready, 1'b1);
    check("c_commit_step",  step_pulse,         1'b0);
    repeat (TICK_DIV - 1) step_clk();
    check("c_early_step",   step_pulse,         1'b0);
    check("c_early_led",    led,                12'hAAA);
    step_clk();
    check("c_next_step",    step_pulse,         1'b1);
    check("c_next_led",     led,                12'h555);

    // ---------------- 5: freeze, then hold mode ----------------
    step_clk();
    step_clk();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      check($sformatf("f_led_%0d", i),  led,        12'h555);
      check($sformatf("f_step_%0d", i), step_pulse, 1'b0);
      check($sformatf("f_wrap_%0d", i), wrap_pulse, 1'b0);
    end
    en = 1'b1;
    step_clk();
    check("f_resume_nostep", step_pulse,        1'b0);
    step_clk();
    check("f_resume_step",  step_pulse,         1'b1);
    check("f_resume_led",   led,                12'hAAA);
    mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      repeat (TICK_DIV - 1) step_clk();
      check($sformatf("h_gap_%0d", k),   step_pulse, 1'b0);
      step_clk();
      check($sformatf("h_step_%0d", k),  step_pulse, 1'b1);
      check($sformatf("h_led_%0d", k),   led,        12'hAAA);
      check($sformatf("h_wrap_%0d", k),  wrap_pulse, 1'b0);
    end

    // ---------------- 6: reset during LOAD ----------------
    mode                 = 2'b00;
    load_if.load_valid   = 1'b1;
    load_if.load_pattern = 12'h123;
    step_clk();
    check("x_load_ready",   load_if.load_ready, 1'b0);
    rst                  = 1'b1;
    load_if.load_valid   = 1'b0;
    step_clk();
    check("x_rst_led",      led,                BASE);
    check("x_rst_ready",    load_if.load_ready, 1'b0);
    check("x_rst_step",     step_pulse,         1'b0);
    check("x_rst_wrap",     wrap_pulse,         1'b0);
    rst = 1'b0;
    repeat (TICK_DIV - 1) step_clk();
    check("x_no_commit",    led,                BASE);
    step_clk();
    check("x_first_step",   led,                12'h1DA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
